// File: rtl/cpu_trap_controller.sv
// Trap entry/return sequencer driving the single CSR write port, pipeline stall/flush and PC redirect.
// Optional vectored interrupt dispatch is enabled by defining CPU_TRAP_VECTORED_EN.
module cpu_trap_controller #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [1:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic            mret_valid,
   input  logic [XLEN-1:0] next_pc,
   input  logic            irq_msi,
   input  logic            irq_mti,
   input  logic            irq_mei,
   input  logic [XLEN-1:0] mstatus_rd,
   input  logic [XLEN-1:0] mie_rd,
   input  logic [XLEN-1:0] mtvec_rd,
   input  logic [XLEN-1:0] mepc_rd,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      M_MSTATUS,
      REDIRECT
   } state_t;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   state_t          state_q, state_d;
   logic [XLEN-1:0] trapPc_q, trapPc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic            isMret_q, isMret_d;

   logic            csrWen_q, csrWen_d;
   logic [11:0]     csrWaddr_q, csrWaddr_d;
   logic [XLEN-1:0] csrWdata_q, csrWdata_d;
   logic            busy_q, busy_d;
   logic            redirectValid_q, redirectValid_d;
   logic [XLEN-1:0] redirectPc_q, redirectPc_d;

   logic            irqMeiPending, irqMsiPending, irqMtiPending;
   logic [XLEN-1:0] trapStatus, mretStatus, trapBase;
   logic            unusedMieBits;

   assign irqMeiPending = mstatus_rd[3] & irq_mei & mie_rd[11];
   assign irqMsiPending = mstatus_rd[3] & irq_msi & mie_rd[3];
   assign irqMtiPending = mstatus_rd[3] & irq_mti & mie_rd[7];
   assign unusedMieBits = ^{mie_rd[XLEN-1:12], mie_rd[10:8], mie_rd[6:4], mie_rd[2:0]};

   always_comb begin
      trapStatus        = mstatus_d;
      trapStatus[7]     = mstatus_d[3];
      trapStatus[3]     = 1'b0;
      trapStatus[12:11] = 2'b11;
      mretStatus        = mstatus_d;
      mretStatus[3]     = mstatus_d[7];
      mretStatus[7]     = 1'b1;
      mretStatus[12:11] = 2'b11;
   end

   assign trapBase = {mtvec_d[XLEN-1:2], 2'b00};

   // Event arbitration happens only in IDLE; once a sequence starts it runs to completion.
   always_comb begin
      state_d   = state_q;
      trapPc_d  = trapPc_q;
      mcause_d  = mcause_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      isMret_d  = isMret_q;
      case (state_q)
         IDLE: begin
            if (exc_valid || irqMeiPending || irqMsiPending || irqMtiPending || mret_valid) begin
               mstatus_d = mstatus_rd;
               mtvec_d   = mtvec_rd;
               mepc_d    = mepc_rd;
            end
            if (exc_valid) begin
               state_d  = W_MEPC;
               isMret_d = 1'b0;
               trapPc_d = exc_pc;
               case (exc_cause)
                  2'd0:    mcause_d = XLEN'(0);
                  2'd1:    mcause_d = XLEN'(2);
                  2'd2:    mcause_d = XLEN'(3);
                  default: mcause_d = XLEN'(11);
               endcase
            end else if (irqMeiPending || irqMsiPending || irqMtiPending) begin
               state_d  = W_MEPC;
               isMret_d = 1'b0;
               trapPc_d = next_pc;
               if (irqMeiPending)
                  mcause_d = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
               else if (irqMsiPending)
                  mcause_d = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
               else
                  mcause_d = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
            end else if (mret_valid) begin
               state_d  = M_MSTATUS;
               isMret_d = 1'b1;
            end
         end
         W_MEPC:    state_d = W_MCAUSE;
         W_MCAUSE:  state_d = W_MSTATUS;
         W_MSTATUS: state_d = REDIRECT;
         M_MSTATUS: state_d = REDIRECT;
         REDIRECT:  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so they appear registered in that state's cycle.
   always_comb begin
      csrWen_d        = 1'b0;
      csrWaddr_d      = 12'h000;
      csrWdata_d      = '0;
      busy_d          = (state_d != IDLE);
      redirectValid_d = 1'b0;
      redirectPc_d    = '0;
      case (state_d)
         W_MEPC: begin
            csrWen_d   = 1'b1;
            csrWaddr_d = ADDR_MEPC;
            csrWdata_d = {trapPc_d[XLEN-1:2], 2'b00};
         end
         W_MCAUSE: begin
            csrWen_d   = 1'b1;
            csrWaddr_d = ADDR_MCAUSE;
            csrWdata_d = mcause_d;
         end
         W_MSTATUS: begin
            csrWen_d   = 1'b1;
            csrWaddr_d = ADDR_MSTATUS;
            csrWdata_d = trapStatus;
         end
         M_MSTATUS: begin
            csrWen_d   = 1'b1;
            csrWaddr_d = ADDR_MSTATUS;
            csrWdata_d = mretStatus;
         end
         REDIRECT: begin
            redirectValid_d = 1'b1;
            if (isMret_d) begin
               redirectPc_d = {mepc_d[XLEN-1:2], 2'b00};
            end else begin
               redirectPc_d = trapBase;
`ifdef CPU_TRAP_VECTORED_EN
               if (mtvec_d[1:0] == 2'b01 && mcause_d[XLEN-1])
                  redirectPc_d = trapBase + {mcause_d[XLEN-3:0], 2'b00};
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         trapPc_q        <= '0;
         mcause_q        <= '0;
         mstatus_q       <= '0;
         mtvec_q         <= '0;
         mepc_q          <= '0;
         isMret_q        <= 1'b0;
         csrWen_q        <= 1'b0;
         csrWaddr_q      <= 12'h000;
         csrWdata_q      <= '0;
         busy_q          <= 1'b0;
         redirectValid_q <= 1'b0;
         redirectPc_q    <= '0;
      end else begin
         state_q         <= state_d;
         trapPc_q        <= trapPc_d;
         mcause_q        <= mcause_d;
         mstatus_q       <= mstatus_d;
         mtvec_q         <= mtvec_d;
         mepc_q          <= mepc_d;
         isMret_q        <= isMret_d;
         csrWen_q        <= csrWen_d;
         csrWaddr_q      <= csrWaddr_d;
         csrWdata_q      <= csrWdata_d;
         busy_q          <= busy_d;
         redirectValid_q <= redirectValid_d;
         redirectPc_q    <= redirectPc_d;
      end
   end

   assign csr_wen        = csrWen_q;
   assign csr_waddr      = csrWaddr_q;
   assign csr_wdata      = csrWdata_q;
   assign stall          = busy_q;
   assign flush          = busy_q;
   assign busy           = busy_q;
   assign redirect_valid = redirectValid_q;
   assign redirect_pc    = redirectPc_q;

endmodule

// File: doc/cpu_trap_controller.md
Name: cpu_trap_controller

Overview:
- Sequences trap entry and return through the single CSR-file write port.
- Each cycle, arbitrates among a writeback-stage exception, the three machine interrupt lines and mret.
- On acceptance it stalls and flushes the pipeline, writes mepc, mcause and mstatus one per cycle, then issues a one-cycle PC redirect.
- Sits between the writeback stage, the CSR file and the fetch-stage PC mux.

Parameters:
XLEN, 32, datapath and CSR width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
exc_valid  in  1  writeback-stage exception this cycle
exc_cause  in  2  0 instr-misaligned, 1 illegal, 2 breakpoint, 3 ecall
exc_pc  in  XLEN  PC of the faulting instruction
mret_valid  in  1  mret retiring in writeback
next_pc  in  XLEN  PC of the next instruction to commit (mepc for interrupts)
irq_msi, irq_mti, irq_mei  in  1 each  level-sensitive interrupt lines
mstatus_rd  in  XLEN  current mstatus[31:0] from the CSR file
mie_rd  in  XLEN  current mie
mtvec_rd  in  XLEN  current mtvec
mepc_rd  in  XLEN  current mepc
csr_wen  out  1  controller write strobe; the CSR-port mux selects the controller when high
csr_waddr  out  12  CSR address being written
csr_wdata  out  XLEN  CSR write data
stall  out  1  hold all pipeline stages
flush  out  1  squash IF..MEM
redirect_valid  out  1  one-cycle strobe to load redirect_pc
redirect_pc  out  XLEN  trap-handler or return target
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0.
- Outputs are registered. Decisions are made on the clock edge from inputs sampled in IDLE.
- Event priority in IDLE: exc_valid > pending interrupt > mret_valid.
- Interrupt pending = mstatus_rd[3] (MIE) & irq_x & mie_rd bit. MEI uses bit 11, MSI bit 3, MTI bit 7.
- Interrupt priority among lines: MEI > MSI > MTI.
- mcause values:
  - Exceptions 0/1/2/3 map to mcause 0, 2, 3, 11.
  - Interrupts map to {1, cause}: MSI 3, MTI 7, MEI 11 (bit XLEN-1 set).
- On acceptance, the following are latched: trap PC (exc_pc for exceptions, next_pc for interrupts), mcause, mstatus_rd, mtvec_rd, mepc_rd.
- Trap FSM: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> REDIRECT -> IDLE.
  - W_MEPC: csr_wen=1, waddr 0x341, wdata = trap PC with bits [1:0] forced to 0.
  - W_MCAUSE: waddr 0x342, wdata = mcause.
  - W_MSTATUS: waddr 0x300, wdata = latched mstatus with MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 2'b11.
  - REDIRECT: redirect_valid=1, redirect_pc = {mtvec[XLEN-1:2], 2'b00}, csr_wen=0.
- Mret FSM: IDLE -> M_MSTATUS -> REDIRECT -> IDLE.
  - M_MSTATUS: waddr 0x300, wdata: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
  - REDIRECT: redirect_pc = latched mepc with bits [1:0] = 0.
- Latency, with acceptance at edge 0:
  - Trap: writes occur in cycles 1, 2, 3; redirect in cycle 4; IDLE in cycle 5.
  - Mret: write in cycle 1; redirect in cycle 2.
- stall, flush and busy are high in every non-IDLE state, including REDIRECT.
- While busy, exc_valid and mret_valid are ignored; they are squashed by the flush.
- IRQ lines are level-sensitive and are re-evaluated only in IDLE.
  - A line that drops before acceptance is not taken.
  - A line that drops after acceptance does not abort the sequence.
- The cycle after REDIRECT is IDLE, and a new event may be accepted that cycle. The interrupt-enable check then sees the updated mstatus, so an MIE=0 handler is not re-interrupted.
- Simultaneous exc_valid and interrupt: the exception is taken; the interrupt is evaluated again in IDLE.
- Reset asserted mid-sequence aborts immediately: no further writes, and redirect is not issued.
- csr_wen is never high in IDLE or REDIRECT.

Optional Feature:
CPU_TRAP_VECTORED_EN:
- Defined: if mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*cause (cause = mcause without bit XLEN-1). Exceptions still go to the base address.
- Undefined: mtvec[1:0] is ignored and all traps redirect to the base address.

Test Plan:
- Ecall: exc_valid=1, cause=3, exc_pc=0x0000_0104, mtvec=0x0000_0200, mstatus=0x8 -> cycles 1..3 write 0x341=0x104, 0x342=11, 0x300=0x1880; cycle 4 redirect_pc=0x200; stall high cycles 1..4.
- Interrupt arbitration: MIE=1, mie=0x888, irq_mti=irq_mei=1, next_pc=0x300 -> mcause write 0x8000_000B, mepc 0x300; MTI is not taken afterwards because the written mstatus has MIE=0.
- Masking: mstatus MIE=0 with irq_mei=1 for 20 cycles -> busy, csr_wen and stall stay 0.
- Mret: mret_valid=1, mstatus=0x1880, mepc=0x108 -> cycle 1 writes 0x300=0x1888; cycle 2 redirect_pc=0x108; then IDLE.
- Simultaneous exc_valid (cause 1) and irq_mei, plus reset at cycle 2 -> mepc is written in cycle 1 only; after reset all outputs are 0 and no redirect is issued.
- CPU_TRAP_VECTORED_EN defined: mtvec=0x201, MTI taken -> redirect_pc=0x21C; illegal instruction -> redirect_pc=0x200.
